pool_se_seq_ctrl: RTL and testbench

- Sequencer for the pooling result BRAM (`DATA_WIDTH`-wide, 2401 words, 1-cycle registered read, 4-word parallel SE read port).
- Phase 1: accepts per-channel pooled results from the pooling engine and writes them to consecutive addresses from 0.
- Phase 2: reads them back in groups of 4 words (addr, +1, +2, +3) to the SE block under a valid/ready handshake.
- Sits between the pooling engine, the BRAM and the SE FC stage; owns all BRAM address/enable lines.

---
 rtl/pool_se_pkg.sv | 17 +
 rtl/pool_se_seq_ctrl_if.sv | 38 +++
 rtl/pool_se_rd_ptr.sv | 43 ++++
 rtl/pool_se_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_pool_se_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_se_pkg.sv
`default_nettype none
// pool_se_pkg: shared types and constants for the pooling-result sequencer.
// Rev 1.0
package pool_se_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int SE_LANES   = 4;
  localparam int BRAM_DEPTH = 2401;

endpackage
`default_nettype wire

// File: rtl/pool_se_seq_ctrl_if.sv
`default_nettype none
// pool_se_seq_ctrl_if: pooling-engine, BRAM and SE-side signals of the sequencer.
// Rev 1.0
interface pool_se_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_AW      = 20,
  parameter int WR_AW      = 32
);
  logic                  start;
  logic [RD_AW-1:0]      num_ch;
  logic                  pool_valid;
  logic [DATA_WIDTH-1:0] pool_data;
  logic                  bram_wr_en;
  logic [WR_AW-1:0]      bram_wr_addr;
  logic [DATA_WIDTH-1:0] bram_data_in;
  logic [RD_AW-1:0]      bram_rd_addr;
  logic                  se_valid;
  logic                  se_ready;
  logic [3:0]            se_lane_mask;
  logic                  se_last;
  logic                  busy;
  logic                  done;
  logic                  cfg_err;
  logic [31:0]           stall_cycles;

  modport master (
    output start, num_ch, pool_valid, pool_data, se_ready,
    input  bram_wr_en, bram_wr_addr, bram_data_in, bram_rd_addr, se_valid,
           se_lane_mask, se_last, busy, done, cfg_err, stall_cycles
  );

  modport slave (
    input  start, num_ch, pool_valid, pool_data, se_ready,
    output bram_wr_en, bram_wr_addr, bram_data_in, bram_rd_addr, se_valid,
           se_lane_mask, se_last, busy, done, cfg_err, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pool_se_rd_ptr.sv
`default_nettype none
// pool_se_rd_ptr: SE read pointer, look-ahead read address, lane mask and last flag.
// Rev 1.0
module pool_se_rd_ptr
  import pool_se_pkg::*;
#(
  parameter int RD_AW = 20
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                clr_i,
  input  wire logic                adv_i,
  input  wire logic [RD_AW-1:0]    num_ch_i,
  output logic      [RD_AW-1:0]    rd_addr_o,
  output logic      [SE_LANES-1:0] lane_mask_o,
  output logic                     last_o
);

  logic [RD_AW-1:0] ptr_q, ptr_d;
  logic [RD_AW:0]   w_ptr_ext;
  logic [RD_AW:0]   w_num_ext;

  // Advancing on the handshake cycle itself keeps the BRAM one step ahead,
  // so back-to-back groups stream at one per cycle.
  assign rd_addr_o = adv_i ? (ptr_q + RD_AW'(SE_LANES)) : ptr_q;
  assign ptr_d     = clr_i ? '0 : rd_addr_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign w_ptr_ext = {1'b0, ptr_q};
  assign w_num_ext = {1'b0, num_ch_i};

  for (genvar k = 0; k < SE_LANES; k++) begin : g_lane
    assign lane_mask_o[k] = (w_ptr_ext + (RD_AW+1)'(k)) < w_num_ext;
  end

  assign last_o = (w_ptr_ext + (RD_AW+1)'(SE_LANES)) >= w_num_ext;

endmodule
`default_nettype wire

// File: rtl/pool_se_seq_ctrl.sv
`default_nettype none
// pool_se_seq_ctrl: writes pooled channels to BRAM, then streams them to SE in 4-word groups.
// Optional stall counter enabled by POOL_SE_STALL_CNT_EN. Rev 1.0
module pool_se_seq_ctrl
  import pool_se_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = BRAM_DEPTH,
  parameter int RD_AW      = 20,
  parameter int WR_AW      = 32
) (
  input wire logic          clk,
  input wire logic          rst,
  pool_se_seq_ctrl_if.slave bus
);

  localparam logic [RD_AW-1:0] C_DEPTH = RD_AW'(DEPTH);

  state_e            state_q, state_d;
  logic [RD_AW-1:0]  num_ch_q;
  logic [RD_AW-1:0]  wr_cnt_q;
  logic              cfg_err_q;
  logic              se_valid_q, se_valid_d;

  logic              w_start_ok;
  logic              w_wr_last;
  logic              w_handshake;
  logic              w_last_hs;
  logic [RD_AW-1:0]  w_rd_addr;
  logic [SE_LANES-1:0] w_lane_mask;
  logic              w_last;

  assign w_start_ok  = bus.start && (state_q == ST_IDLE);
  assign w_wr_last   = (state_q == ST_WRITE) && bus.pool_valid &&
                       (wr_cnt_q == (num_ch_q - 1'b1));
  assign w_handshake = se_valid_q && bus.se_ready;
  assign w_last_hs   = w_handshake && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if ((bus.num_ch == '0) || (bus.num_ch > C_DEPTH)) state_d = ST_DONE;
          else                                               state_d = ST_WRITE;
        end
      end
      ST_WRITE: if (w_wr_last) state_d = ST_READ;
      ST_READ:  if (w_last_hs) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // First READ cycle only presents address 0; data is valid one cycle later.
  assign se_valid_d = (state_q == ST_READ) && !w_last_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_ch_q   <= '0;
      wr_cnt_q   <= '0;
      cfg_err_q  <= 1'b0;
      se_valid_q <= 1'b0;
    end else begin
      se_valid_q <= se_valid_d;
      if (w_start_ok) begin
        if (bus.num_ch > C_DEPTH) begin
          cfg_err_q <= 1'b1;
        end else if (bus.num_ch != '0) begin
          num_ch_q  <= bus.num_ch;
          wr_cnt_q  <= '0;
          cfg_err_q <= 1'b0;
        end
      end else if ((state_q == ST_WRITE) && bus.pool_valid) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  pool_se_rd_ptr #(
    .RD_AW (RD_AW)
  ) u_rd_ptr (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q != ST_READ),
    .adv_i       (w_handshake),
    .num_ch_i    (num_ch_q),
    .rd_addr_o   (w_rd_addr),
    .lane_mask_o (w_lane_mask),
    .last_o      (w_last)
  );

  always_comb begin
    bus.bram_wr_en   = 1'b0;
    bus.bram_wr_addr = '0;
    bus.bram_data_in = {DATA_WIDTH{1'b0}};
    bus.bram_rd_addr = w_rd_addr;
    bus.se_valid     = se_valid_q;
    bus.se_lane_mask = se_valid_q ? w_lane_mask : 4'b0000;
    bus.se_last      = se_valid_q && w_last;
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = (state_q == ST_DONE);
    bus.cfg_err      = cfg_err_q;
    if (state_q == ST_WRITE) begin
      bus.bram_wr_en   = bus.pool_valid;
      bus.bram_wr_addr = WR_AW'(wr_cnt_q);
      bus.bram_data_in = bus.pool_data;
    end
  end

`ifdef POOL_SE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         stall_q <= '0;
    else if (w_start_ok)                             stall_q <= '0;
    else if (se_valid_q && !bus.se_ready && !(&stall_q)) stall_q <= stall_q + 32'd1;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool_se_seq_ctrl.sv
`default_nettype none
// tb_pool_se_seq_ctrl: directed stimulus with a queue-based scoreboard and BRAM model.
// Rev 1.0
module tb_pool_se_seq_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [19:0]      base;
    logic [3:0]       mask;
    logic             last;
    logic [3:0][31:0] d;
  } grp_t;

  logic clk;
  logic rst;

  pool_se_seq_ctrl_if #(.DATA_WIDTH(32), .RD_AW(20), .WR_AW(32)) bus ();

  pool_se_seq_ctrl #(
    .DATA_WIDTH (32),
    .DEPTH      (2401),
    .RD_AW      (20),
    .WR_AW      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_done = 0;
  int   hs_cyc   = 0;
  bit   hs_pend  = 0;
  wr_t  exp_wr[$];
  grp_t exp_grp[$];

  logic [31:0] mem  [0:2409];
  logic [31:0] rd_q [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Registered 4-word read port, write port as the real BRAM.
  always @(posedge clk) begin
    if (bus.bram_wr_en) mem[bus.bram_wr_addr] <= bus.bram_data_in;
    for (int k = 0; k < 4; k++) rd_q[k] <= mem[int'(bus.bram_rd_addr) + k];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin
    if (bus.bram_wr_en) begin
      if (exp_wr.size() == 0) fail("unexpected_write");
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(bus.bram_wr_addr), 64'(w.addr));
        chk("wr_data", 64'(bus.bram_data_in), 64'(w.data));
      end
    end
    if (bus.se_valid) begin
      if (exp_grp.size() == 0) fail("unexpected_se_valid");
      else begin
        grp_t g;
        g = exp_grp[0];
        if (bus.se_ready) begin
          void'(exp_grp.pop_front());
          chk("grp_mask", 64'(bus.se_lane_mask), 64'(g.mask));
          chk("grp_last", 64'(bus.se_last), 64'(g.last));
          chk("grp_next_addr", 64'(bus.bram_rd_addr), 64'(g.base) + 64'd4);
          for (int k = 0; k < 4; k++)
            if (g.mask[k]) chk($sformatf("grp_lane%0d_data", k), 64'(rd_q[k]), 64'(g.d[k]));
          if (g.last) begin
            hs_pend = 1'b1;
            hs_cyc  = cyc;
          end
        end else begin
          chk("stall_addr_hold", 64'(bus.bram_rd_addr), 64'(g.base));
        end
      end
    end
    if (bus.done) begin
      if (exp_done == 0) fail("unexpected_done");
      else exp_done--;
      if (hs_pend) begin
        chk("done_latency", 64'(cyc), 64'(hs_cyc + 1));
        hs_pend = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int n);
    bus.num_ch = 20'(n);
    bus.start  = 1'b1;
    exp_done++;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic feed(input int n, input bit gap, input logic [31:0] tag);
    for (int i = 0; i < n; i++) begin
      bus.pool_valid = 1'b1;
      bus.pool_data  = tag + 32'(i);
      exp_wr.push_back('{addr: 32'(i), data: tag + 32'(i)});
      tick();
      if (gap) begin
        bus.pool_valid = 1'b0;
        bus.pool_data  = 32'hDEAD_BEEF;
        tick();
      end
    end
    bus.pool_valid = 1'b0;
  endtask

  task automatic push_grp(input int base, input logic [3:0] mask, input logic last,
                          input logic [31:0] tag);
    grp_t g;
    g.base = 20'(base);
    g.mask = mask;
    g.last = last;
    for (int k = 0; k < 4; k++) g.d[k] = tag + 32'(base + k);
    exp_grp.push_back(g);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 300);
    chk({nm, "_idle_timeout"}, 64'(bus.busy), 64'd0);
    chk({nm, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    chk({nm, "_groups_left"}, 64'(exp_grp.size()), 64'd0);
    chk({nm, "_done_left"}, 64'(exp_done), 64'd0);
    tick();
  endtask

  task automatic wait_hs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.se_valid && bus.se_ready) && n < 100);
    if (n >= 100) fail("handshake_timeout");
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_busy"},     64'(bus.busy), 64'd0);
    chk({nm, "_done"},     64'(bus.done), 64'd0);
    chk({nm, "_se_valid"}, 64'(bus.se_valid), 64'd0);
    chk({nm, "_mask"},     64'(bus.se_lane_mask), 64'd0);
    chk({nm, "_last"},     64'(bus.se_last), 64'd0);
    chk({nm, "_wr_en"},    64'(bus.bram_wr_en), 64'd0);
    chk({nm, "_rd_addr"},  64'(bus.bram_rd_addr), 64'd0);
    chk({nm, "_cfg_err"},  64'(bus.cfg_err), 64'd0);
    chk({nm, "_stall"},    64'(bus.stall_cycles), 64'd0);
  endtask

  initial begin
    int exp_stall;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_ch     = '0;
    bus.pool_valid = 1'b0;
    bus.pool_data  = '0;
    bus.se_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // 8 channels, back-to-back writes, SE always ready.
    start_layer(8);
    push_grp(0, 4'b1111, 1'b0, 32'h1000_0000);
    push_grp(4, 4'b1111, 1'b1, 32'h1000_0000);
    feed(8, 1'b0, 32'h1000_0000);
    wait_idle("ch8");

    // 6 channels with gapped pool_valid; final group has two live lanes.
    start_layer(6);
    push_grp(0, 4'b1111, 1'b0, 32'h2000_0000);
    push_grp(4, 4'b0011, 1'b1, 32'h2000_0000);
    feed(6, 1'b1, 32'h2000_0000);
    wait_idle("ch6");

    // 12 channels, SE stalls three cycles on the second group.
    start_layer(12);
    push_grp(0, 4'b1111, 1'b0, 32'h3000_0000);
    push_grp(4, 4'b1111, 1'b0, 32'h3000_0000);
    push_grp(8, 4'b1111, 1'b1, 32'h3000_0000);
    feed(12, 1'b0, 32'h3000_0000);
    wait_hs();
    tick();
    bus.se_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.se_ready = 1'b1;
    wait_idle("ch12");
`ifdef POOL_SE_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall));

    // Zero channels: straight to DONE, nothing written or streamed.
    start_layer(0);
    wait_idle("ch0");

    // Oversized layer flags cfg_err; the next valid start clears it.
    start_layer(2500);
    wait_idle("ch2500");
    chk("cfg_err_set", 64'(bus.cfg_err), 64'd1);
    start_layer(4);
    chk("cfg_err_cleared", 64'(bus.cfg_err), 64'd0);
    push_grp(0, 4'b1111, 1'b1, 32'h4000_0000);
    feed(4, 1'b0, 32'h4000_0000);
    wait_idle("ch4_after_err");

    // Asynchronous reset in the middle of READ.
    start_layer(16);
    push_grp(0,  4'b1111, 1'b0, 32'h5000_0000);
    push_grp(4,  4'b1111, 1'b0, 32'h5000_0000);
    push_grp(8,  4'b1111, 1'b0, 32'h5000_0000);
    push_grp(12, 4'b1111, 1'b1, 32'h5000_0000);
    feed(16, 1'b0, 32'h5000_0000);
    wait_hs();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midread_rst");
    exp_grp.delete();
    exp_done--;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    start_layer(4);
    push_grp(0, 4'b1111, 1'b1, 32'h6000_0000);
    feed(4, 1'b0, 32'h6000_0000);
    wait_idle("ch4_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
